ddr_rd_arbiter: RTL and testbench
=================================

// Module: ddr_rd_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the DDR slave read channel (addr + data/back).
//  Sits between two AXI-style read masters and the DDR slave read port, in the DDR core clock domain.
//  Holds one burst in flight at a time: grant lasts from address accept until the RD_DATA_LAST beat.
//  Routes read data only to the granted master.
// PARAMETERS
//  ID_WIDTH   4   width of all read ID fields; passed through unchanged.
// PORTS
//  clk                  in   1         DDR core clock (DDR_SLAVE_CLK); the only clock.
//  rst                  in   1         synchronous, active-high reset.
//  Mx_RD_ADDR_ID        in   ID_WIDTH  master x (x=0,1) read ID.
//  Mx_RD_ADDR           in   32        master x read address.
//  Mx_RD_ADDR_LEN       in   8         master x burst length-1.
//  Mx_RD_ADDR_BURST     in   2         master x burst type.
//  Mx_RD_ADDR_VALID     in   1         master x address valid.
//  Mx_RD_ADDR_READY     out  1         master x address ready.
//  Mx_RD_BACK_ID        out  ID_WIDTH  read data ID to master x.
//  Mx_RD_DATA           out  32        read data to master x.
//  Mx_RD_DATA_RESP      out  2         read response to master x.
//  Mx_RD_DATA_LAST      out  1         last beat to master x.
//  Mx_RD_DATA_VALID     out  1         data valid to master x.
//  Mx_RD_DATA_READY     in   1         master x data ready.
//  S_RD_ADDR_ID/ADDR/LEN/BURST/VALID out  -  to DDR slave; widths as Mx_*.
//  S_RD_ADDR_READY      in   1         from DDR slave.
//  S_RD_BACK_ID/DATA/DATA_RESP/DATA_LAST/DATA_VALID in  -  from DDR slave.
//  S_RD_DATA_READY      out  1         to DDR slave.
// BEHAVIOUR
//  Registered state: state{IDLE,ADDR,DATA}; gnt (0/1); last (0/1).
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, last=1 (M0 wins first tie).
//  While state=IDLE, all Mx_*_READY=0, Mx_RD_DATA_VALID=0, S_RD_ADDR_VALID=0, S_RD_DATA_READY=0.
//  This also holds in the cycle after reset.
//  IDLE: exactly one Mx_VALID high -> gnt<=x.
//   Both high -> gnt<=~last.
//   State -> ADDR.
//   No VALID -> stay in IDLE.
//  ADDR: S_RD_ADDR_* = M[gnt] address fields, passed combinationally.
//   M[gnt]_RD_ADDR_READY = S_RD_ADDR_READY; the other master's READY=0.
//   On S_RD_ADDR_VALID & S_RD_ADDR_READY -> DATA.
//  DATA: M[gnt]_RD_* data outputs = S_RD_* data inputs.
//   M[gnt]_RD_DATA_VALID = S_RD_DATA_VALID; S_RD_DATA_READY = M[gnt]_RD_DATA_READY.
//   The other master sees VALID=0.
//   On VALID & READY & LAST -> IDLE, last<=gnt.
//  Latency: Mx_VALID in IDLE -> S_RD_ADDR_VALID the next cycle; data path adds 0 cycles.
//  Non-granted master: address READY stays 0 and its request stays pending, never dropped.
//  A master deasserting VALID in ADDR is an AXI violation; no recovery.
//  Non-granted data outputs: VALID=0; data/ID/RESP/LAST are don't-care and driven 0.
//  S_RD_BACK_ID is not compared against the granted ID; it is forwarded as-is.
//  LEN=0 (single beat): first beat is also LAST; DATA->IDLE after one beat.
//  Back-to-back bursts: at least one IDLE cycle between bursts, i.e. 2-cycle grant turnaround.
//  Data beats on S before address accept are not possible (state machine enforces this).
//  rst mid-burst: abort to IDLE on the next edge.
//   The downstream DDR slave must be reset in the same cycle; the in-flight burst is lost.
// CONFIGURATION
//  DDR_RD_ARB_STATS_EN defined: adds outputs M0_BURST_CNT[15:0] and M1_BURST_CNT[15:0].
//   Each counts completed bursts (LAST handshake) for its master.
//   Counters saturate at 16'hFFFF and clear on rst.
//  DDR_RD_ARB_STATS_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset, then M0 only: ADDR=0x100, LEN=3.
//     -> S_RD_ADDR_VALID one cycle later with ADDR=0x100.
//     -> 4 beats routed to M0; M1_RD_DATA_VALID stays 0; back to IDLE.
//  2. M0 and M1 VALID in the same cycle after reset.
//     -> M0 served first, then M1 (grant order 0,1).
//     -> Repeated simultaneous requests alternate 0,1,0,1.
//  3. LEN=0 with M1_RD_DATA_READY=0 for 5 cycles.
//     -> S_RD_DATA_READY=0 for those 5 cycles; the single beat completes when READY rises.
//  4. Assert rst during beat 2 of an 8-beat burst.
//     -> Next cycle: state=IDLE and all VALID/READY outputs 0.
//     -> A new M0 request is then served normally.
//  5. M1 held VALID during an M0 burst.
//     -> M1_RD_ADDR_READY=0 throughout.
//     -> M1 is granted in the cycle after M0's LAST handshake plus one IDLE cycle.
//  6. With DDR_RD_ARB_STATS_EN: 3 M0 bursts and 1 M1 burst -> M0_BURST_CNT=3, M1_BURST_CNT=1.
//     Preload M0_BURST_CNT=16'hFFFF via force, run one more burst -> count stays 16'hFFFF.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Two-master round-robin arbiter for the DDR slave read channel, one burst in flight at a time.
// Optional feature macro DDR_RD_ARB_STATS_EN adds saturating per-master completed-burst counters.
module ddr_rd_arbiter #(
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] M0_RD_ADDR_ID,
  input  logic [31:0]         M0_RD_ADDR,
  input  logic [7:0]          M0_RD_ADDR_LEN,
  input  logic [1:0]          M0_RD_ADDR_BURST,
  input  logic                M0_RD_ADDR_VALID,
  output logic                M0_RD_ADDR_READY,
  output logic [ID_WIDTH-1:0] M0_RD_BACK_ID,
  output logic [31:0]         M0_RD_DATA,
  output logic [1:0]          M0_RD_DATA_RESP,
  output logic                M0_RD_DATA_LAST,
  output logic                M0_RD_DATA_VALID,
  input  logic                M0_RD_DATA_READY,
  input  logic [ID_WIDTH-1:0] M1_RD_ADDR_ID,
  input  logic [31:0]         M1_RD_ADDR,
  input  logic [7:0]          M1_RD_ADDR_LEN,
  input  logic [1:0]          M1_RD_ADDR_BURST,
  input  logic                M1_RD_ADDR_VALID,
  output logic                M1_RD_ADDR_READY,
  output logic [ID_WIDTH-1:0] M1_RD_BACK_ID,
  output logic [31:0]         M1_RD_DATA,
  output logic [1:0]          M1_RD_DATA_RESP,
  output logic                M1_RD_DATA_LAST,
  output logic                M1_RD_DATA_VALID,
  input  logic                M1_RD_DATA_READY,
  output logic [ID_WIDTH-1:0] S_RD_ADDR_ID,
  output logic [31:0]         S_RD_ADDR,
  output logic [7:0]          S_RD_ADDR_LEN,
  output logic [1:0]          S_RD_ADDR_BURST,
  output logic                S_RD_ADDR_VALID,
  input  logic                S_RD_ADDR_READY,
  input  logic [ID_WIDTH-1:0] S_RD_BACK_ID,
  input  logic [31:0]         S_RD_DATA,
  input  logic [1:0]          S_RD_DATA_RESP,
  input  logic                S_RD_DATA_LAST,
  input  logic                S_RD_DATA_VALID,
  output logic                S_RD_DATA_READY
`ifdef DDR_RD_ARB_STATS_EN
  ,
  output logic [15:0]         M0_BURST_CNT,
  output logic [15:0]         M1_BURST_CNT
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t state_r, state_nxt;
  logic   gnt_r, gnt_nxt;
  logic   last_r, last_nxt;
  logic   g_avalid, g_dready, addr_hs, last_hs;

  assign g_avalid = gnt_r ? M1_RD_ADDR_VALID : M0_RD_ADDR_VALID;
  assign g_dready = gnt_r ? M1_RD_DATA_READY : M0_RD_DATA_READY;
  assign addr_hs  = (state_r == ADDR) && g_avalid && S_RD_ADDR_READY;
  assign last_hs  = (state_r == DATA) && S_RD_DATA_VALID && g_dready && S_RD_DATA_LAST;

  // State register; last_r=1 after reset so M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt;
      gnt_r   <= gnt_nxt;
      last_r  <= last_nxt;
    end
  end

  // Next-state logic: grant in IDLE, address handshake, then data until LAST.
  always_comb begin
    state_nxt = state_r;
    gnt_nxt   = gnt_r;
    last_nxt  = last_r;
    case (state_r)
      IDLE: begin
        if (M0_RD_ADDR_VALID && M1_RD_ADDR_VALID) begin
          gnt_nxt   = ~last_r;
          state_nxt = ADDR;
        end else if (M0_RD_ADDR_VALID || M1_RD_ADDR_VALID) begin
          gnt_nxt   = M1_RD_ADDR_VALID;
          state_nxt = ADDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR: begin
        if (addr_hs) state_nxt = DATA;
        else         state_nxt = ADDR;
      end
      DATA: begin
        if (last_hs) begin
          state_nxt = IDLE;
          last_nxt  = gnt_r;
        end else begin
          state_nxt = DATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output routing: only the granted master is connected; everything else is driven 0.
  always_comb begin
    M0_RD_ADDR_READY = 1'b0;
    M1_RD_ADDR_READY = 1'b0;
    M0_RD_BACK_ID    = '0;
    M0_RD_DATA       = 32'd0;
    M0_RD_DATA_RESP  = 2'd0;
    M0_RD_DATA_LAST  = 1'b0;
    M0_RD_DATA_VALID = 1'b0;
    M1_RD_BACK_ID    = '0;
    M1_RD_DATA       = 32'd0;
    M1_RD_DATA_RESP  = 2'd0;
    M1_RD_DATA_LAST  = 1'b0;
    M1_RD_DATA_VALID = 1'b0;
    S_RD_ADDR_ID     = '0;
    S_RD_ADDR        = 32'd0;
    S_RD_ADDR_LEN    = 8'd0;
    S_RD_ADDR_BURST  = 2'd0;
    S_RD_ADDR_VALID  = 1'b0;
    S_RD_DATA_READY  = 1'b0;
    case (state_r)
      ADDR: begin
        S_RD_ADDR_ID    = gnt_r ? M1_RD_ADDR_ID    : M0_RD_ADDR_ID;
        S_RD_ADDR       = gnt_r ? M1_RD_ADDR       : M0_RD_ADDR;
        S_RD_ADDR_LEN   = gnt_r ? M1_RD_ADDR_LEN   : M0_RD_ADDR_LEN;
        S_RD_ADDR_BURST = gnt_r ? M1_RD_ADDR_BURST : M0_RD_ADDR_BURST;
        S_RD_ADDR_VALID = g_avalid;
        if (gnt_r) M1_RD_ADDR_READY = S_RD_ADDR_READY;
        else       M0_RD_ADDR_READY = S_RD_ADDR_READY;
      end
      DATA: begin
        S_RD_DATA_READY = g_dready;
        if (gnt_r) begin
          M1_RD_BACK_ID    = S_RD_BACK_ID;
          M1_RD_DATA       = S_RD_DATA;
          M1_RD_DATA_RESP  = S_RD_DATA_RESP;
          M1_RD_DATA_LAST  = S_RD_DATA_LAST;
          M1_RD_DATA_VALID = S_RD_DATA_VALID;
        end else begin
          M0_RD_BACK_ID    = S_RD_BACK_ID;
          M0_RD_DATA       = S_RD_DATA;
          M0_RD_DATA_RESP  = S_RD_DATA_RESP;
          M0_RD_DATA_LAST  = S_RD_DATA_LAST;
          M0_RD_DATA_VALID = S_RD_DATA_VALID;
        end
      end
      default: begin
        S_RD_DATA_READY = 1'b0;
      end
    endcase
  end

`ifdef DDR_RD_ARB_STATS_EN
  logic [15:0] m0_burst_cnt_r, m1_burst_cnt_r;

  // Completed-burst counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_burst_cnt_r <= 16'd0;
      m1_burst_cnt_r <= 16'd0;
    end else if (last_hs) begin
      if (!gnt_r && (m0_burst_cnt_r != 16'hFFFF)) m0_burst_cnt_r <= m0_burst_cnt_r + 16'd1;
      if (gnt_r && (m1_burst_cnt_r != 16'hFFFF))  m1_burst_cnt_r <= m1_burst_cnt_r + 16'd1;
    end
  end

  assign M0_BURST_CNT = m0_burst_cnt_r;
  assign M1_BURST_CNT = m1_burst_cnt_r;
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: owner/phase reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ddr_rd_arbiter;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [IDW-1:0] m_id [2];
  logic [31:0]    m_addr [2];
  logic [7:0]     m_len [2];
  logic [1:0]     m_burst [2];
  logic           m_valid [2];
  logic           m_ardy [2];
  logic [IDW-1:0] m_bid [2];
  logic [31:0]    m_data [2];
  logic [1:0]     m_resp [2];
  logic           m_last [2];
  logic           m_dvalid [2];
  logic           m_dready [2];
  logic [IDW-1:0] s_id, s_bid;
  logic [31:0]    s_addr, s_data;
  logic [7:0]     s_len;
  logic [1:0]     s_burst, s_resp;
  logic           s_avalid, s_ardy, s_last, s_dvalid, s_dready;
`ifdef DDR_RD_ARB_STATS_EN
  logic [15:0]    m0_cnt, m1_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic check_en = 1'b0;

  ddr_rd_arbiter #(.ID_WIDTH(IDW)) dut (
    .clk(clk), .rst(rst),
    .M0_RD_ADDR_ID(m_id[0]), .M0_RD_ADDR(m_addr[0]), .M0_RD_ADDR_LEN(m_len[0]),
    .M0_RD_ADDR_BURST(m_burst[0]), .M0_RD_ADDR_VALID(m_valid[0]), .M0_RD_ADDR_READY(m_ardy[0]),
    .M0_RD_BACK_ID(m_bid[0]), .M0_RD_DATA(m_data[0]), .M0_RD_DATA_RESP(m_resp[0]),
    .M0_RD_DATA_LAST(m_last[0]), .M0_RD_DATA_VALID(m_dvalid[0]), .M0_RD_DATA_READY(m_dready[0]),
    .M1_RD_ADDR_ID(m_id[1]), .M1_RD_ADDR(m_addr[1]), .M1_RD_ADDR_LEN(m_len[1]),
    .M1_RD_ADDR_BURST(m_burst[1]), .M1_RD_ADDR_VALID(m_valid[1]), .M1_RD_ADDR_READY(m_ardy[1]),
    .M1_RD_BACK_ID(m_bid[1]), .M1_RD_DATA(m_data[1]), .M1_RD_DATA_RESP(m_resp[1]),
    .M1_RD_DATA_LAST(m_last[1]), .M1_RD_DATA_VALID(m_dvalid[1]), .M1_RD_DATA_READY(m_dready[1]),
    .S_RD_ADDR_ID(s_id), .S_RD_ADDR(s_addr), .S_RD_ADDR_LEN(s_len), .S_RD_ADDR_BURST(s_burst),
    .S_RD_ADDR_VALID(s_avalid), .S_RD_ADDR_READY(s_ardy),
    .S_RD_BACK_ID(s_bid), .S_RD_DATA(s_data), .S_RD_DATA_RESP(s_resp), .S_RD_DATA_LAST(s_last),
    .S_RD_DATA_VALID(s_dvalid), .S_RD_DATA_READY(s_dready)
`ifdef DDR_RD_ARB_STATS_EN
    , .M0_BURST_CNT(m0_cnt), .M1_BURST_CNT(m1_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the channel and whether its address has been accepted.
  int          mo_owner = -1;
  bit          mo_taken = 1'b0;
  int          mo_pref  = 0;
  logic [46:0] e_s;
  logic [40:0] e_m [2];
  logic        e_dr;
  int          beats [2] = '{0, 0};
  int          vcnt [2] = '{0, 0};
  int          ardy_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    e_s = '0;
    e_m[0] = '0;
    e_m[1] = '0;
    e_dr = 1'b0;
    if (mo_owner >= 0 && !mo_taken) begin
      e_s = {m_id[mo_owner], m_addr[mo_owner], m_len[mo_owner], m_burst[mo_owner], m_valid[mo_owner]};
      e_m[mo_owner] = {s_ardy, 40'd0};
    end else if (mo_owner >= 0) begin
      e_m[mo_owner] = {1'b0, s_bid, s_data, s_resp, s_last, s_dvalid};
      e_dr = m_dready[mo_owner];
    end
    if (check_en) begin
      check("s_addr_chan", {17'd0, s_id, s_addr, s_len, s_burst, s_avalid}, {17'd0, e_s});
      check("m0_chan", {23'd0, m_ardy[0], m_bid[0], m_data[0], m_resp[0], m_last[0], m_dvalid[0]}, {23'd0, e_m[0]});
      check("m1_chan", {23'd0, m_ardy[1], m_bid[1], m_data[1], m_resp[1], m_last[1], m_dvalid[1]}, {23'd0, e_m[1]});
      check("s_data_ready", {63'd0, s_dready}, {63'd0, e_dr});
      for (int i = 0; i < 2; i++) begin
        if (m_dvalid[i] && m_dready[i]) beats[i]++;
        if (m_dvalid[i]) vcnt[i]++;
        if (m_ardy[i]) ardy_cnt[i]++;
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      mo_owner = -1;
      mo_taken = 1'b0;
      mo_pref  = 0;
    end else if (mo_owner < 0) begin
      if (m_valid[0] && m_valid[1]) mo_owner = mo_pref;
      else if (m_valid[0])          mo_owner = 0;
      else if (m_valid[1])          mo_owner = 1;
      mo_taken = 1'b0;
    end else if (!mo_taken) begin
      if (m_valid[mo_owner] && s_ardy) mo_taken = 1'b1;
    end else if (s_dvalid && s_last && m_dready[mo_owner]) begin
      mo_pref  = 1 - mo_owner;
      mo_owner = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    s_dvalid = 1'b0;
    s_last = 1'b0;
    s_ardy = 1'b1;
    m_dready[0] = 1'b1;
    m_dready[1] = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic request(input int m, input logic [31:0] a, input logic [7:0] len);
    m_id[m]    = (m == 0) ? 4'hA : 4'hB;
    m_addr[m]  = a;
    m_len[m]   = len;
    m_burst[m] = 2'b01;
    m_valid[m] = 1'b1;
  endtask

  // Wait for a grant, accept the address, then play the burst from the slave side.
  task automatic serve_one(output int who, input int stall, output int low_cnt);
    who = -1;
    low_cnt = 0;
    for (int n = 0; n < 40 && who < 0; n++) begin
      @(negedge clk);
      if (m_ardy[0])      who = 0;
      else if (m_ardy[1]) who = 1;
      tick();
    end
    if (who < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL grant_timeout: got no address READY within 40 cycles, required a grant");
      return;
    end
    m_valid[who] = 1'b0;
    for (int b = 0; b <= int'(m_len[who]); b++) begin
      s_dvalid = 1'b1;
      s_bid    = m_id[who];
      s_data   = m_addr[who] + 32'(b);
      s_resp   = 2'(b);
      s_last   = (b == int'(m_len[who]));
      if (b == 0 && stall > 0) begin
        m_dready[who] = 1'b0;
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          if (!s_dready) low_cnt++;
          tick();
        end
        m_dready[who] = 1'b1;
      end
      tick();
    end
    s_dvalid = 1'b0;
    s_last = 1'b0;
  endtask

  int who, lc, b0, b1, v1, a1;
  int gord [7];
  int exp_ord [7] = '{0, 1, 0, 1, 0, 1, 0};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_id[i] = '0; m_addr[i] = 32'd0; m_len[i] = 8'd0; m_burst[i] = 2'd0;
      m_valid[i] = 1'b0; m_dready[i] = 1'b1;
    end
    s_ardy = 1'b1; s_bid = '0; s_data = 32'd0; s_resp = 2'd0; s_last = 1'b0; s_dvalid = 1'b0;

    // 1: single M0 burst, LEN=3
    do_reset();
    @(negedge clk);
    check("t1_reset_idle", {61'd0, s_avalid, s_dready, m_ardy[0]}, 64'd0);
    b0 = beats[0]; v1 = vcnt[1];
    tick();
    request(0, 32'h100, 8'd3);
    s_ardy = 1'b0;
    @(negedge clk);
    check("t1_no_svalid_same_cycle", {63'd0, s_avalid}, 64'd0);
    tick();
    @(negedge clk);
    check("t1_svalid_next_cycle", {63'd0, s_avalid}, 64'd1);
    check("t1_saddr", {32'd0, s_addr}, 64'h100);
    tick();
    s_ardy = 1'b1;
    serve_one(who, 0, lc);
    check("t1_who", 64'(who), 64'd0);
    check("t1_beats", 64'(beats[0] - b0), 64'd4);
    check("t1_m1_valid_seen", 64'(vcnt[1] - v1), 64'd0);
    @(negedge clk);
    check("t1_back_idle", {63'd0, s_avalid}, 64'd0);
    tick();

    // 2: simultaneous requests alternate
    do_reset();
    request(0, 32'h200, 8'd1); request(1, 32'h280, 8'd0);
    serve_one(gord[0], 0, lc); serve_one(gord[1], 0, lc);
    request(0, 32'h210, 8'd0); request(1, 32'h290, 8'd2);
    serve_one(gord[2], 0, lc); serve_one(gord[3], 0, lc);
    request(0, 32'h220, 8'd0);
    serve_one(gord[4], 0, lc);
    request(0, 32'h230, 8'd1); request(1, 32'h2A0, 8'd0);
    serve_one(gord[5], 0, lc); serve_one(gord[6], 0, lc);
    for (int i = 0; i < 7; i++) check($sformatf("t2_grant_order[%0d]", i), 64'(gord[i]), 64'(exp_ord[i]));

    // 3: single beat with a 5-cycle master stall
    do_reset();
    b1 = beats[1];
    request(1, 32'h300, 8'd0);
    serve_one(who, 5, lc);
    check("t3_who", 64'(who), 64'd1);
    check("t3_s_ready_low_cycles", 64'(lc), 64'd5);
    check("t3_beats", 64'(beats[1] - b1), 64'd1);

    // 4: reset during beat 2 of an 8-beat burst
    do_reset();
    request(0, 32'h400, 8'd7);
    tick();
    tick();
    m_valid[0] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_dvalid = 1'b1; s_bid = 4'hA; s_data = 32'h400 + 32'(b); s_resp = 2'd0; s_last = 1'b0;
      if (b == 2) rst = 1'b1;
      tick();
    end
    rst = 1'b0; s_dvalid = 1'b0;
    @(negedge clk);
    check("t4_after_rst_outputs", {60'd0, s_avalid, s_dready, m_dvalid[0], m_ardy[0]}, 64'd0);
    tick();
    b0 = beats[0];
    request(0, 32'h480, 8'd0);
    serve_one(who, 0, lc);
    check("t4_new_who", 64'(who), 64'd0);
    check("t4_new_beats", 64'(beats[0] - b0), 64'd1);

    // 5: M1 waits during an M0 burst, then gets a 2-cycle turnaround
    do_reset();
    a1 = ardy_cnt[1];
    request(0, 32'h500, 8'd3);
    tick();
    request(1, 32'h5A0, 8'd1);
    serve_one(who, 0, lc);
    check("t5_first_who", 64'(who), 64'd0);
    check("t5_m1_ready_during_m0", 64'(ardy_cnt[1] - a1), 64'd0);
    s_ardy = 1'b0;
    @(negedge clk);
    check("t5_idle_gap", {63'd0, s_avalid}, 64'd0);
    tick();
    @(negedge clk);
    check("t5_m1_granted", {27'd0, s_avalid, s_id, s_addr}, {27'd0, 1'b1, 4'hB, 32'h5A0});
    tick();
    s_ardy = 1'b1;
    serve_one(who, 0, lc);
    check("t5_second_who", 64'(who), 64'd1);

`ifdef DDR_RD_ARB_STATS_EN
    // 6: burst counters and saturation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      request(0, 32'h600 + 32'(i * 16), 8'd1);
      serve_one(who, 0, lc);
    end
    request(1, 32'h700, 8'd0);
    serve_one(who, 0, lc);
    check("t6_m0_cnt", {48'd0, m0_cnt}, 64'd3);
    check("t6_m1_cnt", {48'd0, m1_cnt}, 64'd1);
    force dut.m0_burst_cnt_r = 16'hFFFF;
    tick();
    release dut.m0_burst_cnt_r;
    request(0, 32'h800, 8'd0);
    serve_one(who, 0, lc);
    check("t6_m0_saturated", {48'd0, m0_cnt}, 64'hFFFF);
    check("t6_m1_unchanged", {48'd0, m1_cnt}, 64'd1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
